mc_ctrl: RTL and testbench

Multi-cycle control FSM for the P5 MIPS core. It replaces per-instruction combinational decode with a sequenced FETCH/DECODE/EXE/MEM/WB flow over a shared ALU, IR and ALUOut datapath. It supports add, sub, sll/nop, slt, jr, ori, lw, sw, sb, beq, bne, lui, jal and j. Data-memory accesses use a req/ack handshake so the data memory (DM) may stall.

---
 rtl/mc_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencing FSM for the P5 MIPS core: drives the shared PC/IR/ALU/ALUOut datapath
// and a stallable data-memory handshake. state_o encoding follows the state list order (IDLE=0 .. HALT=13).
module mc_ctrl #(
    parameter int CNT_W        = 32,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             dm_ack,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       ext_op,
    output logic [1:0]       pc_src,
    output logic             dm_req,
    output logic             dm_we,
    output logic             dm_sb,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXE_R  = 4'd3,
        S_EXE_I  = 4'd4,
        S_WB_ALU = 4'd5,
        S_MADDR  = 4'd6,
        S_MRD    = 4'd7,
        S_WB_MEM = 4'd8,
        S_MWR    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JR     = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_R   = 6'h00, OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2b, OP_SB  = 6'h28, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_J   = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] F_ADD  = 6'h20, F_SUB  = 6'h22, F_SLL  = 6'h00, F_SLT  = 6'h2a;
    localparam logic [5:0] F_JR   = 6'h08;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    logic is_r, c_ralu, c_imm, c_mem, c_br, c_jmp, c_jr;

    assign is_r   = (op == OP_R);
    assign c_ralu = is_r & ((funct == F_ADD) | (funct == F_SUB) | (funct == F_SLL) | (funct == F_SLT));
    assign c_jr   = is_r & (funct == F_JR);
    assign c_imm  = (op == OP_ORI) | (op == OP_LUI);
    assign c_mem  = (op == OP_LW) | (op == OP_SW) | (op == OP_SB);
    assign c_br   = (op == OP_BEQ) | (op == OP_BNE);
    assign c_jmp  = (op == OP_J) | (op == OP_JAL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        reg_dst   = 2'b00;
        wd_sel    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = 3'd0;
        ext_op    = 2'b00;
        pc_src    = 2'b00;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_sb     = 1'b0;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here so BRANCH only needs the compare.
                alu_src_b = 2'b11;
                ext_op    = 2'b01;
                if (c_ralu)     state_d = S_EXE_R;
                else if (c_imm) state_d = S_EXE_I;
                else if (c_mem) state_d = S_MADDR;
                else if (c_br)  state_d = S_BRANCH;
                else if (c_jmp) state_d = S_JUMP;
                else if (c_jr)  state_d = S_JR;
                else begin
                    illegal = 1'b1;
                    retire  = 1'b1;
                    state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                end
            end
            S_EXE_R: begin
                alu_src_a = 1'b1;
                case (funct)
                    F_SUB:   alu_op = 3'd1;
                    F_SLL:   alu_op = 3'd3;
                    F_SLT:   alu_op = 3'd4;
                    default: alu_op = 3'd0;
                endcase
                state_d = S_WB_ALU;
            end
            S_EXE_I: begin
                // lui relies on rs=0 in its encoding, so the same OR path yields imm<<16.
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = (op == OP_LUI) ? 2'b10 : 2'b00;
                alu_op    = 3'd2;
                state_d   = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                reg_dst   = is_r ? 2'b01 : 2'b00;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 2'b01;
                state_d   = (op == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                dm_req = 1'b1;
                if (dm_ack) state_d = S_WB_MEM;
            end
            S_WB_MEM: begin
                reg_write = 1'b1;
                wd_sel    = 2'b01;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MWR: begin
                dm_req = 1'b1;
                dm_we  = 1'b1;
                dm_sb  = (op == OP_SB);
                if (dm_ack) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 3'd1;
                pc_src    = 2'b01;
                pc_write  = ((op == OP_BEQ) & zero) | ((op == OP_BNE) & ~zero);
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
                if (op == OP_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b10;
                    wd_sel    = 2'b10;
                end
                state_d = S_FETCH;
            end
            S_JR: begin
                pc_src   = 2'b11;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign instr_cnt = cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized instruction stream against a per-instruction cycle-plan model of the control sequence.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  op, funct;
    logic        zero, dm_ack;
    logic        pc_write, ir_write, reg_write, alu_src_a;
    logic [1:0]  reg_dst, wd_sel, alu_src_b, ext_op, pc_src;
    logic [2:0]  alu_op;
    logic        dm_req, dm_we, dm_sb, retire, illegal;
    logic [31:0] instr_cnt;
    logic [3:0]  state_o;

    mc_ctrl #(.CNT_W(32), .ILLEGAL_TRAP(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero), .dm_ack(dm_ack),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .wd_sel(wd_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .ext_op(ext_op), .pc_src(pc_src), .dm_req(dm_req), .dm_we(dm_we), .dm_sb(dm_sb),
        .retire(retire), .illegal(illegal), .instr_cnt(instr_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write, ir_write, reg_write;
        logic [1:0] reg_dst, wd_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] ext_op, pc_src;
        logic       dm_req, dm_we, dm_sb, retire, illegal;
        logic [3:0] state;
    } ctl_t;

    typedef struct {
        ctl_t e;
        bit   ack;
    } step_t;

    typedef enum {I_ADD, I_SUB, I_SLL, I_SLT, I_JR, I_ORI, I_LW, I_SW, I_SB,
                  I_BEQ, I_BNE, I_LUI, I_JAL, I_J, I_BAD} ins_t;

    ctl_t  obs;
    step_t plan_q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    logic [31:0] exp_cnt = 0;

    assign obs = {pc_write, ir_write, reg_write, reg_dst, wd_sel, alu_src_a, alu_src_b, alu_op,
                  ext_op, pc_src, dm_req, dm_we, dm_sb, retire, illegal, state_o};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] encode(input ins_t i);
        logic [5:0] rf;
        rf = 6'($urandom);
        case (i)
            I_ADD:   return {6'h00, 6'h20};
            I_SUB:   return {6'h00, 6'h22};
            I_SLL:   return {6'h00, 6'h00};
            I_SLT:   return {6'h00, 6'h2a};
            I_JR:    return {6'h00, 6'h08};
            I_ORI:   return {6'h0d, rf};
            I_LW:    return {6'h23, rf};
            I_SW:    return {6'h2b, rf};
            I_SB:    return {6'h28, rf};
            I_BEQ:   return {6'h04, rf};
            I_BNE:   return {6'h05, rf};
            I_LUI:   return {6'h0f, rf};
            I_JAL:   return {6'h03, rf};
            I_J:     return {6'h02, rf};
            default: return {6'h3f, rf};
        endcase
    endfunction

    task automatic push(input ctl_t e, input bit ack);
        step_t st;
        st.e   = e;
        st.ack = ack;
        plan_q.push_back(st);
    endtask

    // Expected per-cycle control words for one instruction, from the sequencing rules.
    task automatic plan(input ins_t i, input bit z, input int w);
        ctl_t s;
        plan_q.delete();
        s = '0; s.ir_write = 1; s.pc_write = 1; s.alu_src_b = 2'b01; s.state = 4'd1;
        push(s, bit'($urandom_range(0, 1)));
        s = '0; s.alu_src_b = 2'b11; s.ext_op = 2'b01; s.state = 4'd2;
        if (i == I_BAD) begin s.illegal = 1; s.retire = 1; end
        push(s, bit'($urandom_range(0, 1)));
        case (i)
            I_ADD, I_SUB, I_SLL, I_SLT: begin
                s = '0; s.alu_src_a = 1; s.state = 4'd3;
                s.alu_op = (i == I_SUB) ? 3'd1 : (i == I_SLL) ? 3'd3 : (i == I_SLT) ? 3'd4 : 3'd0;
                push(s, bit'($urandom_range(0, 1)));
                s = '0; s.reg_write = 1; s.reg_dst = 2'b01; s.retire = 1; s.state = 4'd5;
                push(s, bit'($urandom_range(0, 1)));
            end
            I_ORI, I_LUI: begin
                s = '0; s.alu_src_a = 1; s.alu_src_b = 2'b10; s.alu_op = 3'd2; s.state = 4'd4;
                s.ext_op = (i == I_LUI) ? 2'b10 : 2'b00;
                push(s, bit'($urandom_range(0, 1)));
                s = '0; s.reg_write = 1; s.retire = 1; s.state = 4'd5;
                push(s, bit'($urandom_range(0, 1)));
            end
            I_LW, I_SW, I_SB: begin
                s = '0; s.alu_src_a = 1; s.alu_src_b = 2'b10; s.ext_op = 2'b01; s.state = 4'd6;
                push(s, bit'($urandom_range(0, 1)));
                for (int k = 0; k <= w; k++) begin
                    s = '0; s.dm_req = 1;
                    if (i == I_LW) s.state = 4'd7;
                    else begin
                        s.state = 4'd9; s.dm_we = 1; s.dm_sb = (i == I_SB);
                        s.retire = (k == w);
                    end
                    push(s, k == w);
                end
                if (i == I_LW) begin
                    s = '0; s.reg_write = 1; s.wd_sel = 2'b01; s.retire = 1; s.state = 4'd8;
                    push(s, bit'($urandom_range(0, 1)));
                end
            end
            I_BEQ, I_BNE: begin
                s = '0; s.alu_src_a = 1; s.alu_op = 3'd1; s.pc_src = 2'b01; s.retire = 1;
                s.state = 4'd10; s.pc_write = (i == I_BEQ) ? z : !z;
                push(s, bit'($urandom_range(0, 1)));
            end
            I_J, I_JAL: begin
                s = '0; s.pc_src = 2'b10; s.pc_write = 1; s.retire = 1; s.state = 4'd11;
                if (i == I_JAL) begin s.reg_write = 1; s.reg_dst = 2'b10; s.wd_sel = 2'b10; end
                push(s, bit'($urandom_range(0, 1)));
            end
            I_JR: begin
                s = '0; s.pc_src = 2'b11; s.pc_write = 1; s.retire = 1; s.state = 4'd12;
                push(s, bit'($urandom_range(0, 1)));
            end
            default: ;
        endcase
    endtask

    task automatic exec(input ins_t i, input bit z, input int w);
        logic [11:0] enc;
        enc = encode(i);
        plan(i, z, w);
        foreach (plan_q[k]) begin
            @(negedge clk);
            op     = enc[11:6];
            funct  = enc[5:0];
            zero   = z;
            dm_ack = plan_q[k].ack;
            #1;
            if (k == 0) chk($sformatf("%s cnt", i.name()), 64'(instr_cnt), 64'(exp_cnt));
            chk($sformatf("%s step%0d", i.name(), k), 64'(obs), 64'(plan_q[k].e));
        end
        exp_cnt = exp_cnt + 32'd1;
    endtask

    initial begin
        reset_n = 1'b0; op = '0; funct = '0; zero = 1'b0; dm_ack = 1'b0;
        #1;
        chk("reset outputs", 64'(obs), 64'(0));
        chk("reset cnt", 64'(instr_cnt), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("idle outputs", 64'(obs), 64'(0));

        exec(I_ADD, 1'b0, 0);
        exec(I_LW, 1'b0, 3);
        exec(I_SB, 1'b0, 0);
        exec(I_SW, 1'b0, 0);
        exec(I_BEQ, 1'b1, 0);
        exec(I_BNE, 1'b1, 0);
        exec(I_JAL, 1'b0, 0);
        exec(I_JR, 1'b0, 0);
        for (int n = 0; n < 300; n++)
            exec(ins_t'($urandom_range(0, 13)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 4)));

        // Asynchronous reset in the middle of a stalled load.
        begin
            logic [11:0] enc;
            enc = encode(I_LW);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                op = enc[11:6]; funct = enc[5:0]; dm_ack = 1'b0;
            end
            #1;
            chk("mrd dm_req before reset", 64'(dm_req), 64'(1));
            #2;
            reset_n = 1'b0;
            #1;
            chk("mrd reset dm_req", 64'(dm_req), 64'(0));
            chk("mrd reset outputs", 64'(obs), 64'(0));
            chk("mrd reset cnt", 64'(instr_cnt), 64'(0));
            @(negedge clk);
            reset_n = 1'b1;
            exp_cnt = 0;
        end

        exec(I_ORI, 1'b0, 0);
        exec(I_BAD, 1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            ctl_t h;
            h = '0; h.state = 4'd13;
            @(negedge clk);
            dm_ack = bit'($urandom_range(0, 1));
            op = 6'($urandom);
            #1;
            chk($sformatf("halt step%0d", k), 64'(obs), 64'(h));
            chk($sformatf("halt cnt%0d", k), 64'(instr_cnt), 64'(exp_cnt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
